spi_reg_controller: RTL and testbench
=====================================

// Module: spi_reg_controller
// PURPOSE
//  Transaction sequencer above spi_slave_interface: decodes received SPI bytes into register
//  read/write accesses on a local 8-bit register bank and sets the byte the slave shifts out next.
//  Frame = ss low: byte 0 is the command, later bytes are write data or read slots.
//  Register contents and a write strobe go to the rest of the design.
// PARAMETERS
//  NUM_REGS  8      number of 8-bit registers, 2..128
//  ADDR_W    $clog2(NUM_REGS)  local address width (derived)
//  IDLE_TX   8'hA5  tx_data during the command byte and while idle
//  ERR_TX    8'hFF  tx_data for reads of an out-of-range address
// PORTS
//  clk       in   1            system clock
//  n_reset   in   1            asynchronous active-low reset
//  ss        in   1            slave select, synchronised to clk, active low
//  rx_data   in   8            byte received by spi_slave_interface
//  rx_valid  in   1            one-clk pulse: rx_data holds a complete byte
//  tx_data   out  8            to spi_slave_interface send_buffer
//  regs_q    out  8*NUM_REGS   register bank contents, reg i at [8*i+:8]
//  wr_stb    out  1            one-clk pulse when a register is written
//  wr_addr   out  ADDR_W       address of the register being written (valid with wr_stb)
//  busy      out  1            high while a frame is in progress (state != IDLE)
//  err       out  1            sticky: command addressed an out-of-range register; cleared by next command
// BEHAVIOUR
//  Reset: state=IDLE, all regs 8'h00, tx_data=IDLE_TX, wr_stb=0, wr_addr=0, busy=0, err=0.
//  Command byte: bit7 = 1 write / 0 read; bits[6:0] = start address.
//  FSM: IDLE -> CMD when ss falls. CMD -> WRITE or READ on rx_valid.
//   If the address is >= NUM_REGS: CMD -> ERROR and err=1.
//   WRITE, READ and ERROR stay until ss rises; any state -> IDLE on the clk after ss is seen high.
//  WRITE: each rx_valid writes rx_data to reg[addr] and pulses wr_stb on the same edge; then addr advances.
//  READ: on the command's rx_valid edge, tx_data <= reg[addr]. On each later rx_valid: addr advances
//   and tx_data <= reg[new addr]. Latency is 1 clk after rx_valid, so tx_data is ready well before the next byte.
//  ERROR: writes are ignored, tx_data = ERR_TX, no wr_stb.
//  ss high has priority over rx_valid in the same cycle: the byte is discarded.
//  rx_valid while IDLE is ignored. A partial byte at ss rise needs no action (no rx_valid arrives).
//  tx_data returns to IDLE_TX on entering IDLE. regs_q persists across frames.
//  n_reset asserted mid-frame: immediate return to reset values, including the register bank.
// CONFIGURATION
//  SPI_CTRL_AUTOINC_EN defined: addr increments after each data byte; wraps NUM_REGS-1 -> 0.
//  Not defined: addr stays fixed for the whole frame. Repeated writes hit the same register;
//   repeated reads return the same register.
// STRUCTURE
//  Package spi_ctrl_pkg holds:
//   state_t enum {IDLE, CMD, WRITE, READ, ERROR}, CMD_WR_BIT = 7, CMD_ADDR_MSB = 6,
//   default IDLE_TX / ERR_TX constants.
//  Sub-module spi_reg_bank: NUM_REGS x 8 flops, one write port (we, waddr, wdata), one
//   combinational read port, flattened q output, async reset to 0.
//  spi_reg_controller holds the FSM, address counter, tx_data register and err flag.
// TESTING
//  1 Frame ss low, bytes 8'h83, 8'h5A, 8'h3C (AUTOINC_EN):
//    reg3=5A, reg4=3C, two wr_stb pulses with wr_addr 3 then 4.
//  2 After test 1, frame 8'h03 + two dummy bytes: tx_data = A5 during the command byte,
//    then 5A, then 3C, each 1 clk after rx_valid.
//  3 Write at wrap (NUM_REGS=8): 8'h87, 8'h11, 8'h22 -> reg7=11, reg0=22.
//  4 Out-of-range 8'h90, 8'h77: err=1, tx_data=FF, no wr_stb, regs unchanged.
//    The next frame's command clears err.
//  5 ss rises after the command byte 8'h85 with no data: IDLE next clk, busy=0, tx_data=A5.
//    rx_valid coincident with the ss rise is dropped, reg5 unchanged.
//  6 n_reset low mid-write frame: all regs 0, state IDLE.
//    Macro undefined: 8'h82, 8'h11, 8'h22 -> reg2=22, reg3 untouched.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
// Define SPI_CTRL_AUTOINC_EN to enable address auto-increment.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ,
    ERROR
  } state_t;

  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;

  localparam logic [7:0] IDLE_TX_DEF = 8'hA5;
  localparam logic [7:0] ERR_TX_DEF  = 8'hFF;

endpackage

// File: rtl/spi_reg_bank.sv
// Register bank: one write port, one combinational read port,
// flattened contents output, async reset to zero.
module spi_reg_bank #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [7:0]            rdata,
  output logic [8*NUM_REGS-1:0] q
);

  logic [7:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

  always_comb begin
    q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      q[8*i +: 8] = mem[i];
    end
  end

endmodule

// File: rtl/spi_reg_controller.sv
// SPI transaction sequencer: command decode, register access, tx byte.
// Define SPI_CTRL_AUTOINC_EN to advance the address after each data byte.
module spi_reg_controller
  import spi_ctrl_pkg::*;
#(
  parameter int         NUM_REGS = 8,
  parameter int         ADDR_W   = $clog2(NUM_REGS),
  parameter logic [7:0] IDLE_TX  = IDLE_TX_DEF,
  parameter logic [7:0] ERR_TX   = ERR_TX_DEF
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  ss,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic [8*NUM_REGS-1:0] regs_q,
  output logic                  wr_stb,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  busy,
  output logic                  err
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d, addr_inc;
  logic [ADDR_W-1:0] raddr, cmd_addr, waddr_d;
  logic [7:0]        tx_d, rdata;
  logic              err_d, we, stb_d, oor;

  assign cmd_addr = rx_data[ADDR_W-1:0];
  assign oor = int'(rx_data[CMD_ADDR_MSB:0]) >= NUM_REGS;

`ifdef SPI_CTRL_AUTOINC_EN
  assign addr_inc = (addr == ADDR_W'(NUM_REGS - 1)) ?
                    '0 : addr + ADDR_W'(1);
`else
  assign addr_inc = addr;
`endif

  always_comb begin
    state_d = state;
    addr_d  = addr;
    tx_d    = tx_data;
    err_d   = err;
    waddr_d = wr_addr;
    raddr   = addr;
    we      = 1'b0;
    stb_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!ss) state_d = CMD;
      end
      CMD: begin
        if (rx_valid) begin
          addr_d = cmd_addr;
          raddr  = cmd_addr;
          err_d  = oor;
          if (oor) begin
            state_d = ERROR;
            tx_d    = ERR_TX;
          end else if (rx_data[CMD_WR_BIT]) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            tx_d    = rdata;
          end
        end
      end
      WRITE: begin
        if (rx_valid) begin
          we      = 1'b1;
          stb_d   = 1'b1;
          waddr_d = addr;
          addr_d  = addr_inc;
        end
      end
      READ: begin
        if (rx_valid) begin
          addr_d = addr_inc;
          raddr  = addr_inc;
          tx_d   = rdata;
        end
      end
      ERROR: begin
        tx_d = ERR_TX;
      end
      default: state_d = IDLE;
    endcase
    // ss high wins over any byte arriving in the same cycle
    if (ss) begin
      state_d = IDLE;
      tx_d    = IDLE_TX;
      addr_d  = addr;
      err_d   = err;
      waddr_d = wr_addr;
      we      = 1'b0;
      stb_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      addr    <= '0;
      tx_data <= IDLE_TX;
      err     <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
    end else begin
      state   <= state_d;
      addr    <= addr_d;
      tx_data <= tx_d;
      err     <= err_d;
      wr_stb  <= stb_d;
      wr_addr <= waddr_d;
    end
  end

  assign busy = (state != IDLE);

  spi_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .n_reset (n_reset),
    .we      (we),
    .waddr   (addr),
    .wdata   (rx_data),
    .raddr   (raddr),
    .rdata   (rdata),
    .q       (regs_q)
  );

endmodule

// File: tb/tb_spi_reg_controller.sv
// Bench for spi_reg_controller: frame-level model plus literal pins.
// Honours SPI_CTRL_AUTOINC_EN the same way the design does.
module tb_spi_reg_controller;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         ss;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic [8*N-1:0] regs_q;
  logic         wr_stb;
  logic [2:0]   wr_addr;
  logic         busy;
  logic         err;

  spi_reg_controller #(.NUM_REGS(N)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .ss       (ss),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .regs_q   (regs_q),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_regs [N];
  logic [7:0] exp_tx;
  logic       exp_stb, exp_busy, exp_err;
  int         exp_waddr;
  int         m_addr;
  bit         m_first, m_wr, m_oor;
  bit         run = 0;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic logic [8*N-1:0] mvec();
    logic [8*N-1:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = m_regs[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
    exp_tx = 8'hA5;
    exp_stb = 0;
    exp_busy = 0;
    exp_err = 0;
    exp_waddr = 0;
    m_first = 1;
  endfunction

  function automatic void model_byte(logic [7:0] b);
    if (m_first) begin
      m_first = 0;
      m_wr = b[7];
      m_addr = int'(b[6:0]);
      m_oor = m_addr >= N;
      exp_err = m_oor;
      if (m_oor) exp_tx = 8'hFF;
      else if (!m_wr) exp_tx = m_regs[m_addr];
    end else if (!m_oor) begin
      if (m_wr) begin
        m_regs[m_addr] = b;
        exp_stb = 1;
        exp_waddr = m_addr;
      end
`ifdef SPI_CTRL_AUTOINC_EN
      m_addr = (m_addr + 1) % N;
`endif
      if (!m_wr) exp_tx = m_regs[m_addr];
    end
  endfunction

  always @(negedge clk) begin
    if (run) begin
      chk("tx_data", 64'(tx_data), 64'(exp_tx));
      chk("regs_q", regs_q, mvec());
      chk("wr_stb", 64'(wr_stb), 64'(exp_stb));
      chk("wr_addr", 64'(wr_addr), 64'(exp_waddr));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("err", 64'(err), 64'(exp_err));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    exp_stb = 0;
  endtask

  task automatic start_frame();
    ss = 0;
    cycle();
    exp_busy = 1;
    m_first = 1;
  endtask

  task automatic send(logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    cycle();
    rx_valid = 0;
    model_byte(b);
    cycle();
    cycle();
  endtask

  task automatic end_frame(bit with_byte, logic [7:0] b);
    ss = 1;
    rx_data = b;
    rx_valid = with_byte;
    cycle();
    rx_valid = 0;
    exp_busy = 0;
    exp_tx = 8'hA5;
    cycle();
  endtask

  task automatic do_reset();
    n_reset = 0;
    ss = 1;
    rx_valid = 0;
    model_reset();
    cycle();
    cycle();
    n_reset = 1;
    cycle();
  endtask

  initial begin
    n_reset = 0;
    ss = 1;
    rx_valid = 0;
    rx_data = 8'h00;
    model_reset();
    run = 1;
    cycle();
    chk("rst_tx", 64'(tx_data), 64'hA5);
    chk("rst_regs", regs_q, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    n_reset = 1;
    cycle();

    // 1: write burst at address 3
    start_frame();
    chk("t1_busy", 64'(busy), 64'h1);
    send(8'h83);
    send(8'h5A);
    send(8'h3C);
    end_frame(0, 8'h00);
`ifdef SPI_CTRL_AUTOINC_EN
    chk("t1_reg3", 64'(regs_q[31:24]), 64'h5A);
    chk("t1_reg4", 64'(regs_q[39:32]), 64'h3C);
    chk("t1_waddr", 64'(wr_addr), 64'h4);
`else
    chk("t1_reg3", 64'(regs_q[31:24]), 64'h3C);
    chk("t1_reg4", 64'(regs_q[39:32]), 64'h00);
    chk("t1_waddr", 64'(wr_addr), 64'h3);
`endif

    // 2: read burst at address 3
    start_frame();
    chk("t2_cmd_tx", 64'(tx_data), 64'hA5);
    send(8'h03);
`ifdef SPI_CTRL_AUTOINC_EN
    chk("t2_tx0", 64'(tx_data), 64'h5A);
    send(8'h00);
    chk("t2_tx1", 64'(tx_data), 64'h3C);
`else
    chk("t2_tx0", 64'(tx_data), 64'h3C);
    send(8'h00);
    chk("t2_tx1", 64'(tx_data), 64'h3C);
`endif
    send(8'h00);
    end_frame(0, 8'h00);
    chk("t2_idle_tx", 64'(tx_data), 64'hA5);

    // 3: write across the top of the bank
    start_frame();
    send(8'h87);
    send(8'h11);
    send(8'h22);
    end_frame(0, 8'h00);
`ifdef SPI_CTRL_AUTOINC_EN
    chk("t3_reg7", 64'(regs_q[63:56]), 64'h11);
    chk("t3_reg0", 64'(regs_q[7:0]), 64'h22);
`else
    chk("t3_reg7", 64'(regs_q[63:56]), 64'h22);
    chk("t3_reg0", 64'(regs_q[7:0]), 64'h00);
`endif

    // 4: out-of-range command
    start_frame();
    send(8'h90);
    chk("t4_err", 64'(err), 64'h1);
    chk("t4_tx", 64'(tx_data), 64'hFF);
    send(8'h77);
    chk("t4_stb", 64'(wr_stb), 64'h0);
    end_frame(0, 8'h00);
    chk("t4_err_sticky", 64'(err), 64'h1);

    // 5: empty write frame, byte coincident with ss rise
    start_frame();
    send(8'h85);
    chk("t5_err_clr", 64'(err), 64'h0);
    end_frame(1, 8'h99);
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_tx", 64'(tx_data), 64'hA5);
    chk("t5_reg5", 64'(regs_q[47:40]), 64'h00);

    // 6: reset mid-frame, then a short write burst
    start_frame();
    send(8'h82);
    send(8'h44);
    do_reset();
    chk("t6_regs", regs_q, 64'h0);
    chk("t6_busy", 64'(busy), 64'h0);
    start_frame();
    send(8'h82);
    send(8'h11);
    send(8'h22);
    end_frame(0, 8'h00);
`ifdef SPI_CTRL_AUTOINC_EN
    chk("t6_reg2", 64'(regs_q[23:16]), 64'h11);
    chk("t6_reg3", 64'(regs_q[31:24]), 64'h22);
`else
    chk("t6_reg2", 64'(regs_q[23:16]), 64'h22);
    chk("t6_reg3", 64'(regs_q[31:24]), 64'h00);
`endif

    // idle bytes are ignored
    rx_data = 8'h81;
    rx_valid = 1;
    cycle();
    rx_valid = 0;
    cycle();
    chk("idle_busy", 64'(busy), 64'h0);

    run = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
